// File: rtl/port_stat_if.sv
// Statistics write channel from the MAC ports: per-port address/increment,
// held by the requester until the collector pulses the matching ack bit.
interface port_stat_if #(
    parameter int NUM_PORTS = 4
);
    logic [7*NUM_PORTS-1:0]  port_addr;
    logic [16*NUM_PORTS-1:0] port_din;
    logic [NUM_PORTS-1:0]    port_req;
    logic [NUM_PORTS-1:0]    port_ack;

    modport master (output port_addr, output port_din, output port_req, input port_ack);
    modport slave  (input port_addr, input port_din, input port_req, output port_ack);
endinterface

// File: rtl/port_stat_collector.sv
// Round-robin collector of per-port statistic deltas into a bank of
// saturating counters, with a single-cycle host read port and clear-on-read.
module port_stat_collector #(
    parameter int         NUM_PORTS     = 4,
    parameter logic [6:0] ADDR_BASE     = 7'h10,
    parameter int         NUM_REGS      = 16,
    parameter int         CNT_W         = 32,
    parameter bit         CLEAR_ON_READ = 1'b1
) (
    input  logic             clk,
    input  logic             rstn,
    port_stat_if.slave       ps,
    input  logic             rd_req,
    input  logic [6:0]       rd_addr,
    output logic [CNT_W-1:0] rd_data,
    output logic             rd_valid,
    input  logic             clr_all,
    output logic [15:0]      addr_err_cnt
);

    localparam int         PTR_W   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int         IDX_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [7:0] ADDR_LO = {1'b0, ADDR_BASE};
    localparam logic [7:0] ADDR_HI = ADDR_LO + 8'(NUM_REGS);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_UPDATE = 1'b1
    } state_t;

    function automatic logic addr_in_range(input logic [6:0] a);
        return ({1'b0, a} >= ADDR_LO) && ({1'b0, a} < ADDR_HI);
    endfunction

    function automatic logic [IDX_W-1:0] reg_idx(input logic [6:0] a);
        logic [7:0] off;
        off = {1'b0, a} - ADDR_LO;
        return off[IDX_W-1:0];
    endfunction

    // Widen by one bit so a carry out means the counter must pin at all-ones.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] base, input logic [15:0] inc);
        logic [CNT_W:0] sum;
        sum = {1'b0, base} + (CNT_W+1)'(inc);
        if (sum[CNT_W]) begin
            return {CNT_W{1'b1}};
        end else begin
            return sum[CNT_W-1:0];
        end
    endfunction

    state_t               state_r, state_nxt_s;
    logic [PTR_W-1:0]     rr_ptr_r, rr_ptr_nxt_s;
    logic [PTR_W-1:0]     grant_r, grant_nxt_s;
    logic [PTR_W:0]       cand_s;
    logic                 found_s;
    logic [6:0]           addr_r, addr_nxt_s;
    logic [15:0]          din_r, din_nxt_s;
    logic [NUM_PORTS-1:0] ack_r, ack_nxt_s, req_elig_s;
    logic                 upd_s;

    logic [CNT_W-1:0]     cnt_r     [NUM_REGS];
    logic [CNT_W-1:0]     cnt_nxt_s [NUM_REGS];
    logic                 rd_hit_s, upd_hit_s;
    logic [IDX_W-1:0]     rd_idx_s, upd_idx_s;
    logic [CNT_W-1:0]     rd_data_r;
    logic                 rd_valid_r;
    logic [15:0]          err_cnt_r;

    assign rd_hit_s  = rd_req & addr_in_range(rd_addr);
    assign rd_idx_s  = reg_idx(rd_addr);
    assign upd_hit_s = upd_s & addr_in_range(addr_r);
    assign upd_idx_s = reg_idx(addr_r);

    // Arbitration and FSM next state; a port acked last cycle is masked out
    // because its request is still visible for one more cycle.
    always_comb begin
        state_nxt_s  = state_r;
        rr_ptr_nxt_s = rr_ptr_r;
        grant_nxt_s  = grant_r;
        addr_nxt_s   = addr_r;
        din_nxt_s    = din_r;
        ack_nxt_s    = '0;
        upd_s        = 1'b0;
        found_s      = 1'b0;
        cand_s       = '0;
        req_elig_s   = ps.port_req & ~ack_r;
        case (state_r)
            ST_IDLE: begin
                for (int k = 0; k < NUM_PORTS; k++) begin
                    cand_s = {1'b0, rr_ptr_r} + (PTR_W+1)'(k);
                    if (cand_s >= (PTR_W+1)'(NUM_PORTS)) begin
                        cand_s = cand_s - (PTR_W+1)'(NUM_PORTS);
                    end else begin
                        cand_s = cand_s;
                    end
                    if (!found_s && req_elig_s[cand_s[PTR_W-1:0]]) begin
                        found_s     = 1'b1;
                        grant_nxt_s = cand_s[PTR_W-1:0];
                    end else begin
                        found_s = found_s;
                    end
                end
                for (int i = 0; i < NUM_PORTS; i++) begin
                    if (found_s && (grant_nxt_s == PTR_W'(i))) begin
                        addr_nxt_s = ps.port_addr[7*i +: 7];
                        din_nxt_s  = ps.port_din[16*i +: 16];
                    end else begin
                        addr_nxt_s = addr_nxt_s;
                    end
                end
                if (found_s) begin
                    state_nxt_s = ST_UPDATE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_UPDATE: begin
                upd_s              = 1'b1;
                ack_nxt_s[grant_r] = 1'b1;
                if (int'(grant_r) == NUM_PORTS - 1) begin
                    rr_ptr_nxt_s = '0;
                end else begin
                    rr_ptr_nxt_s = grant_r + 1'b1;
                end
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM, arbitration state and registered acknowledge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r  <= ST_IDLE;
            rr_ptr_r <= '0;
            grant_r  <= '0;
            addr_r   <= 7'd0;
            din_r    <= 16'd0;
            ack_r    <= '0;
        end else begin
            state_r  <= state_nxt_s;
            rr_ptr_r <= rr_ptr_nxt_s;
            grant_r  <= grant_nxt_s;
            addr_r   <= addr_nxt_s;
            din_r    <= din_nxt_s;
            ack_r    <= ack_nxt_s;
        end
    end

    // Counter next values: clears zero the base first, so a coincident
    // update still lands its delta on top of the cleared value.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            if (clr_all || (CLEAR_ON_READ && rd_hit_s && (rd_idx_s == IDX_W'(r)))) begin
                cnt_nxt_s[r] = '0;
            end else begin
                cnt_nxt_s[r] = cnt_r[r];
            end
            if (upd_hit_s && (upd_idx_s == IDX_W'(r))) begin
                cnt_nxt_s[r] = sat_add(cnt_nxt_s[r], din_r);
            end else begin
                cnt_nxt_s[r] = cnt_nxt_s[r];
            end
        end
    end

    // Counter bank.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_r[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_r[r] <= cnt_nxt_s[r];
            end
        end
    end

    // Host read captures the pre-update value; rd_data holds between reads.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_data_r  <= '0;
            rd_valid_r <= 1'b0;
        end else begin
            rd_valid_r <= rd_req;
            if (rd_req) begin
                rd_data_r <= rd_hit_s ? cnt_r[rd_idx_s] : '0;
            end else begin
                rd_data_r <= rd_data_r;
            end
        end
    end

    // Out-of-range write counter, saturating and untouched by clr_all.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_cnt_r <= 16'd0;
        end else if (upd_s && !addr_in_range(addr_r) && (err_cnt_r != 16'hFFFF)) begin
            err_cnt_r <= err_cnt_r + 16'd1;
        end else begin
            err_cnt_r <= err_cnt_r;
        end
    end

    assign ps.port_ack   = ack_r;
    assign rd_data       = rd_data_r;
    assign rd_valid      = rd_valid_r;
    assign addr_err_cnt  = err_cnt_r;

endmodule
